// File: rtl/byte_packer32_pkg.sv
// Shared byte/lane definitions for the byte packer and the matching byte-select path.
// Lane numbers are logical (arrival order); phys_lane maps them to bit positions in the word.
package byte_packer32_pkg;

   localparam int BYTE_W = 8;
   localparam int LANES  = 4;
   localparam int LANE_W = 2;
   localparam int WORD_W = BYTE_W * LANES;
   localparam int ACC_W  = BYTE_W * (LANES - 1);

   typedef logic [BYTE_W-1:0] byte_t;
   typedef logic [LANE_W-1:0] lane_t;
   typedef logic [LANES-1:0]  keep_t;

   // Logical lane -> physical byte position. The mapping is its own inverse.
   function automatic lane_t phys_lane(input lane_t l, input logic lsb_first);
      if (lsb_first) begin
         return l;
      end else begin
         return 2'd3 - l;
      end
   endfunction

   function automatic logic [4:0] lane_off(input lane_t l);
      return {l, 3'b000};
   endfunction

endpackage

// File: rtl/byte_packer32_lane_dec.sv
// byte_lane_dec: one-hot physical-lane write enable for the logical lane being filled.
module byte_lane_dec
   import byte_packer32_pkg::*;
#(
   parameter bit FIRST_LANE_LSB = 1'b1
) (
   input  logic [LANE_W-1:0] lane,
   input  logic              en,
   output logic [LANES-1:0]  we
);

   // Decode the logical lane to its physical position in the output word.
   always_comb begin
      we = 4'b0000;
      if (en) begin
         case (phys_lane(lane, FIRST_LANE_LSB))
            2'd0:    we = 4'b0001;
            2'd1:    we = 4'b0010;
            2'd2:    we = 4'b0100;
            2'd3:    we = 4'b1000;
            default: we = 4'b0000;
         endcase
      end else begin
         we = 4'b0000;
      end
   end

endmodule

// File: rtl/byte_packer32.sv
// byte_packer32: packs a valid/ready byte stream into 32-bit words at one byte per cycle.
// Defining BYTE_PACKER_FLUSH_EN adds flush/out_keep for emitting partial words.
module byte_packer32
   import byte_packer32_pkg::*;
#(
   parameter bit FIRST_LANE_LSB = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_byte,
   output logic              in_ready,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_word,
   input  logic              out_ready,
`ifdef BYTE_PACKER_FLUSH_EN
   input  logic              flush,
   output logic [LANES-1:0]  out_keep,
`endif
   output logic [LANE_W-1:0] lane
);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [WORD_W-1:0] out_word_q, out_word_d;
   logic              out_valid_q, out_valid_d;
   logic [LANES-1:0]  keep_q, keep_d, keep_s;
   logic [LANES-1:0]  we_s;
   logic [WORD_W-1:0] staged_s, acc_ext_s;
   logic [LANE_W-1:0] src_lane_s;
   logic              hold_busy_s, in_ready_s, accept_s, complete_s, emit_s;

   assign hold_busy_s = out_valid_q && !out_ready;
   assign acc_ext_s   = {8'h00, acc_q};

   // Only the byte that would complete a word (or a flush) must wait for the holding register.
`ifdef BYTE_PACKER_FLUSH_EN
   assign in_ready_s = !((lane_q == 2'd3) && hold_busy_s) && !(flush && hold_busy_s);
`else
   assign in_ready_s = !((lane_q == 2'd3) && hold_busy_s);
`endif

   assign accept_s   = in_valid && in_ready_s;
   assign complete_s = accept_s && (lane_q == 2'd3);

`ifdef BYTE_PACKER_FLUSH_EN
   assign emit_s = complete_s || (flush && ((lane_q != 2'd0) || accept_s) && !hold_busy_s);
`else
   assign emit_s = complete_s;
`endif

   byte_lane_dec #(
      .FIRST_LANE_LSB (FIRST_LANE_LSB)
   ) u_lane_dec (
      .lane (lane_q),
      .en   (accept_s),
      .we   (we_s)
   );

   // Candidate output word: incoming byte, filled accumulator lanes, zeros elsewhere.
   always_comb begin
      staged_s   = 32'h0000_0000;
      src_lane_s = 2'd0;
      for (int p = 0; p < LANES; p++) begin
         src_lane_s = phys_lane(p[1:0], FIRST_LANE_LSB);
         if (we_s[p]) begin
            staged_s[p*BYTE_W +: BYTE_W] = in_byte;
         end else if (src_lane_s < lane_q) begin
            staged_s[p*BYTE_W +: BYTE_W] = acc_ext_s[lane_off(src_lane_s) +: BYTE_W];
         end else begin
            staged_s[p*BYTE_W +: BYTE_W] = 8'h00;
         end
      end
   end

   // Physical keep mask covering every lane filled by this emission.
   always_comb begin
      logic [LANES-1:0] fill_mask;
      fill_mask = 4'b0000;
      keep_s    = 4'b0000;
      case ({1'b0, lane_q} + {2'b00, accept_s})
         3'd1:    fill_mask = 4'b0001;
         3'd2:    fill_mask = 4'b0011;
         3'd3:    fill_mask = 4'b0111;
         3'd4:    fill_mask = 4'b1111;
         default: fill_mask = 4'b0000;
      endcase
      for (int p = 0; p < LANES; p++) begin
         keep_s[p] = fill_mask[phys_lane(p[1:0], FIRST_LANE_LSB)];
      end
   end

   // Next-state: lane counter, accumulator and holding register.
   always_comb begin
      lane_d      = lane_q;
      acc_d       = acc_q;
      out_word_d  = out_word_q;
      out_valid_d = out_valid_q;
      keep_d      = keep_q;
      if (accept_s && (lane_q != 2'd3)) begin
         acc_d[lane_off(lane_q) +: BYTE_W] = in_byte;
      end else begin
         acc_d = acc_q;
      end
      if (emit_s) begin
         lane_d      = 2'd0;
         out_word_d  = staged_s;
         out_valid_d = 1'b1;
         keep_d      = keep_s;
      end else begin
         if (accept_s) begin
            lane_d = lane_q + 2'd1;
         end else begin
            lane_d = lane_q;
         end
         if (out_ready) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
      end
   end

   // State registers; an async reset drops any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q      <= 2'd0;
         acc_q       <= 24'h00_0000;
         out_word_q  <= 32'h0000_0000;
         out_valid_q <= 1'b0;
         keep_q      <= 4'b0000;
      end else begin
         lane_q      <= lane_d;
         acc_q       <= acc_d;
         out_word_q  <= out_word_d;
         out_valid_q <= out_valid_d;
         keep_q      <= keep_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign out_word  = out_word_q;
   assign lane      = lane_q;
`ifdef BYTE_PACKER_FLUSH_EN
   assign out_keep  = keep_q;
`endif

endmodule

// File: tb/tb_byte_packer32.sv
// Scoreboard bench for byte_packer32: LSB-first and MSB-first instances share one stimulus stream.
// Flush checks are compiled in when BYTE_PACKER_FLUSH_EN is defined.
module tb_byte_packer32;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready, flush;
   logic [7:0]  in_byte;
   logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [31:0] out_word_a, out_word_b;
   logic [1:0]  lane_a, lane_b;
   logic [3:0]  keep_a, keep_b;

   int n_checks = 0;
   int n_fail   = 0;
   int stall_cnt = 0;
   int m_lane = 0;
   logic [7:0]  m_bytes [4];
   logic [31:0] q_a [$];
   logic [31:0] q_b [$];
   logic [3:0]  k_a [$];
   logic [3:0]  k_b [$];
   logic        held_a = 1'b0;
   logic [31:0] prev_a = 32'h0;

   always #5 clk = ~clk;

   byte_packer32 #(.FIRST_LANE_LSB(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready_a),
      .out_valid(out_valid_a), .out_word(out_word_a), .out_ready(out_ready),
`ifdef BYTE_PACKER_FLUSH_EN
      .flush(flush), .out_keep(keep_a),
`endif
      .lane(lane_a));

   byte_packer32 #(.FIRST_LANE_LSB(1'b0)) u_dut_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready_b),
      .out_valid(out_valid_b), .out_word(out_word_b), .out_ready(out_ready),
`ifdef BYTE_PACKER_FLUSH_EN
      .flush(flush), .out_keep(keep_b),
`endif
      .lane(lane_b));

`ifndef BYTE_PACKER_FLUSH_EN
   assign keep_a = 4'hF;
   assign keep_b = 4'hF;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w, input logic [3:0] k);
      q_a.push_back(w);
      q_b.push_back({w[7:0], w[15:8], w[23:16], w[31:24]});
      k_a.push_back(k);
      k_b.push_back({k[0], k[1], k[2], k[3]});
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      in_byte  = b;
      for (int t = 0; t < 50 && !accepted; t++) begin
         @(negedge clk);
         if (in_ready_a) accepted = 1'b1;
         else stall_cnt++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!accepted) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: byte %h never accepted", b);
      end else begin
         m_bytes[m_lane] = b;
         m_lane++;
         if (m_lane == 4) begin
            push_word({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]}, 4'hF);
            m_lane = 0;
         end
      end
   endtask

   // Monitor: pops the scoreboard on every completed output handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         held_a = 1'b0;
      end else begin
         if (out_valid_a && out_ready) begin
            if (q_a.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_word_a: got %h expected none", out_word_a);
            end else begin
               check("word_lsb", out_word_a, q_a.pop_front());
`ifdef BYTE_PACKER_FLUSH_EN
               check("keep_lsb", 32'(keep_a), 32'(k_a[0]));
`endif
               void'(k_a.pop_front());
            end
         end
         if (out_valid_b && out_ready) begin
            if (q_b.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_word_b: got %h expected none", out_word_b);
            end else begin
               check("word_msb", out_word_b, q_b.pop_front());
`ifdef BYTE_PACKER_FLUSH_EN
               check("keep_msb", 32'(keep_b), 32'(k_b[0]));
`endif
               void'(k_b.pop_front());
            end
         end
         if (held_a) check("hold_stable", {31'd0, out_valid_a} | (out_word_a ^ prev_a), 32'd1);
         held_a = out_valid_a && !out_ready;
         prev_a = out_word_a;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid_a), 32'd0);
      check("rst_out_word", out_word_a, 32'd0);
      check("rst_lane", 32'(lane_a), 32'd0);
      check("rst_in_ready", 32'(in_ready_a), 32'd1);
      rst_n = 1'b1;

      // Basic word, both lane orders, one-cycle latency.
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      check("latency_valid", 32'(out_valid_a), 32'd1);
      check("t1_word_lsb", out_word_a, 32'h44332211);
      check("t2_word_msb", out_word_b, 32'h11223344);
      check("t1_lane", 32'(lane_a), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      // Continuous stream: no stall across the word boundary.
      stall_cnt = 0;
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      check("t3_no_stall", 32'(stall_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      // Back-pressure on the fourth byte of the second word.
      out_ready = 1'b0;
      for (int i = 1; i <= 7; i++) send_byte(8'(i));
      check("t4_lane3", 32'(lane_a), 32'd3);
      fork
         send_byte(8'h08);
         begin
            repeat (3) begin
               @(negedge clk);
               check("t4_stall_ready", 32'(in_ready_a), 32'd0);
               check("t4_held_word", out_word_a, 32'h04030201);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset mid-word while a word is held.
      out_ready = 1'b0;
      send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
      send_byte(8'hD1); send_byte(8'hD2);
      #2;
      rst_n = 1'b0;
      q_a.delete(); q_b.delete(); k_a.delete(); k_b.delete();
      m_lane = 0;
      #1;
      check("t5_rst_valid", 32'(out_valid_a), 32'd0);
      check("t5_rst_lane", 32'(lane_a), 32'd0);
      check("t5_rst_word", out_word_a, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
      check("t5_clean_word", out_word_a, 32'hA4A3A2A1);
      repeat (2) @(posedge clk);
      #1;

`ifdef BYTE_PACKER_FLUSH_EN
      // Partial word via flush, then a no-op flush at lane 0.
      send_byte(8'hAA); send_byte(8'hBB);
      push_word(32'h0000BBAA, 4'b0011);
      m_lane = 0;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("t6_lane", 32'(lane_a), 32'd0);
      check("t6_keep", 32'(keep_a), 32'h3);
      check("t6_word_lo", 32'(out_word_a[15:0]), 32'h0000BBAA);
      repeat (2) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("t6_idle_flush", 32'(out_valid_a), 32'd0);
`endif

      repeat (4) @(posedge clk);
      #1;
      check("queue_empty", 32'(q_a.size() + q_b.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
